// File: rtl/udt_conn_ctrl.sv
// UDT connection lifecycle controller.
// Sequences handshake/shutdown packet requests with a retry timer, tracks the
// peer's answers and reports every udt_state change on a latest-wins channel.
module udt_conn_ctrl #(
    parameter int unsigned RETRY_CYCLES = 50_000,
    parameter int unsigned MAX_RETRY    = 8,
    parameter logic [31:0] INIT_STATE   = 32'h0000_0000,
    parameter logic [31:0] CONNECTING   = 32'h0000_0001,
    parameter logic [31:0] CONNECTED    = 32'h0000_0010,
    parameter logic [31:0] CLOSING      = 32'h0000_0100,
    parameter logic [31:0] CLOSED       = 32'h0000_1000
) (
    input  logic        ctrl_s_axi_aclk,
    input  logic        ctrl_s_axi_areset,
    input  logic        Req_Connect,
    input  logic        Req_Close,
    output logic        Res_Connect,
    output logic        Res_Close,
    output logic [1:0]  err_code,
    input  logic [31:0] INIT_SEQ,
    output logic        hs_tx_valid,
    input  logic        hs_tx_ready,
    output logic        hs_tx_type,
    output logic [31:0] hs_tx_seq,
    input  logic        hs_rx_valid,
    input  logic        hs_rx_type,
    output logic        hs_rx_ready,
    output logic [31:0] udt_state,
    output logic        state_valid,
    input  logic        state_ready
);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_TMO = 2'd1;
    localparam logic [1:0] ERR_ILL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLOSED, S_SEND_HS, S_WAIT_HS, S_CONNECTED, S_SEND_SHUT, S_WAIT_SHUT
    } state_t;

    state_t      state, nxt;
    logic        conn_blk, close_blk;
    logic [7:0]  retry;
    logic [31:0] timer;

    logic        conn_req, close_req, rx_hs, rx_sh, timeout, retry_left;
    logic        go_conn, go_shut, tx_acc, fire_conn, fire_close, upd;
    logic [1:0]  err_nxt;
    logic [31:0] code_nxt;

    // A request that already got its answer stays masked until it drops.
    assign conn_req   = Req_Connect && !conn_blk;
    assign close_req  = Req_Close && !close_blk;
    assign rx_hs      = hs_rx_valid && !hs_rx_type;
    assign rx_sh      = hs_rx_valid && hs_rx_type;
    assign timeout    = (timer == 32'(RETRY_CYCLES - 1));
    assign retry_left = (retry < 8'(MAX_RETRY));

    // State register.
    always_ff @(posedge ctrl_s_axi_aclk or posedge ctrl_s_axi_areset) begin
        if (ctrl_s_axi_areset) state <= S_IDLE;
        else                   state <= nxt;
    end

    // Next state plus the per-cycle events that drive the datapath.
    always_comb begin
        nxt        = state;
        go_conn    = 1'b0;
        go_shut    = 1'b0;
        tx_acc     = 1'b0;
        fire_conn  = 1'b0;
        fire_close = 1'b0;
        upd        = 1'b0;
        err_nxt    = ERR_OK;
        code_nxt   = udt_state;
        case (state)
            S_IDLE, S_CLOSED: begin
                if (close_req) begin
                    fire_close = 1'b1;
                    err_nxt    = ERR_ILL;
                end else if (conn_req) begin
                    go_conn  = 1'b1;
                    nxt      = S_SEND_HS;
                    upd      = 1'b1;
                    code_nxt = CONNECTING;
                end
            end
            S_SEND_HS: begin
                if (hs_tx_ready) begin
                    tx_acc = 1'b1;
                    nxt    = S_WAIT_HS;
                end
            end
            S_WAIT_HS: begin
                if (rx_hs) begin
                    nxt       = S_CONNECTED;
                    upd       = 1'b1;
                    code_nxt  = CONNECTED;
                    fire_conn = 1'b1;
                end else if (timeout) begin
                    if (retry_left) begin
                        nxt = S_SEND_HS;
                    end else begin
                        nxt       = S_CLOSED;
                        upd       = 1'b1;
                        code_nxt  = CLOSED;
                        fire_conn = 1'b1;
                        err_nxt   = ERR_TMO;
                    end
                end
            end
            S_CONNECTED: begin
                if (close_req) begin
                    go_shut  = 1'b1;
                    nxt      = S_SEND_SHUT;
                    upd      = 1'b1;
                    code_nxt = CLOSING;
                end else if (conn_req) begin
                    fire_conn = 1'b1;
                    err_nxt   = ERR_ILL;
                end else if (rx_sh) begin
                    nxt      = S_CLOSED;
                    upd      = 1'b1;
                    code_nxt = CLOSED;
                end
            end
            S_SEND_SHUT: begin
                if (hs_tx_ready) begin
                    tx_acc = 1'b1;
                    nxt    = S_WAIT_SHUT;
                end
            end
            S_WAIT_SHUT: begin
                if (rx_sh) begin
                    nxt        = S_CLOSED;
                    upd        = 1'b1;
                    code_nxt   = CLOSED;
                    fire_close = 1'b1;
                end else if (timeout) begin
                    if (retry_left) begin
                        nxt = S_SEND_SHUT;
                    end else begin
                        nxt        = S_CLOSED;
                        upd        = 1'b1;
                        code_nxt   = CLOSED;
                        fire_close = 1'b1;
                        err_nxt    = ERR_TMO;
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Packet and rx handshake outputs decoded from the state alone.
    always_comb begin
        hs_tx_valid = (state == S_SEND_HS) || (state == S_SEND_SHUT);
        hs_tx_type  = (state == S_SEND_SHUT);
        hs_rx_ready = (state == S_WAIT_HS) || (state == S_CONNECTED) || (state == S_WAIT_SHUT);
    end

    // Counters, captured sequence, response pulses and state report.
    always_ff @(posedge ctrl_s_axi_aclk or posedge ctrl_s_axi_areset) begin
        if (ctrl_s_axi_areset) begin
            retry       <= '0;
            timer       <= '0;
            hs_tx_seq   <= '0;
            Res_Connect <= 1'b0;
            Res_Close   <= 1'b0;
            err_code    <= ERR_OK;
            udt_state   <= INIT_STATE;
            state_valid <= 1'b0;
        end else begin
            if (go_conn) hs_tx_seq <= INIT_SEQ;
            if (go_conn || go_shut) begin
                retry <= '0;
            end else if (tx_acc) begin
                retry <= retry + 8'd1;
            end
            if (tx_acc) begin
                timer <= '0;
            end else if (state == S_WAIT_HS || state == S_WAIT_SHUT) begin
                timer <= timer + 32'd1;
            end
            Res_Connect <= fire_conn;
            Res_Close   <= fire_close;
            if (fire_conn || fire_close) err_code <= err_nxt;
            if (upd) udt_state <= code_nxt;
            // A fresh change always wins over a same-cycle consume.
            if (upd)              state_valid <= 1'b1;
            else if (state_ready) state_valid <= 1'b0;
        end
    end

    // Request masking: set when a response is issued, cleared once the request drops.
    always_ff @(posedge ctrl_s_axi_aclk or posedge ctrl_s_axi_areset) begin
        if (ctrl_s_axi_areset) begin
            conn_blk  <= 1'b0;
            close_blk <= 1'b0;
        end else begin
            if (!Req_Connect)   conn_blk  <= 1'b0;
            else if (fire_conn) conn_blk  <= 1'b1;
            if (!Req_Close)      close_blk <= 1'b0;
            else if (fire_close) close_blk <= 1'b1;
        end
    end

endmodule

// File: tb/tb_udt_conn_ctrl.sv
// Bench for udt_conn_ctrl: directed and randomized connect/close attempts,
// with expectations computed per attempt from tx counts, retry spacing,
// response codes and the sequence of reported state codes.
module tb_udt_conn_ctrl;

    localparam int RC = 16;
    localparam int MR = 3;
    localparam logic [31:0] C_INIT = 32'h0, C_CONN = 32'h1, C_UP = 32'h10;
    localparam logic [31:0] C_CLSG = 32'h100, C_CLSD = 32'h1000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        Req_Connect, Req_Close, Res_Connect, Res_Close;
    logic [1:0]  err_code;
    logic [31:0] INIT_SEQ, hs_tx_seq, udt_state;
    logic        hs_tx_valid, hs_tx_ready, hs_tx_type;
    logic        hs_rx_valid, hs_rx_type, hs_rx_ready;
    logic        state_valid, state_ready;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    bit bp_mode = 1'b0;
    bit prev_v = 1'b0;
    int req_edge, rx_e;
    logic [31:0] cur_seq;

    // Event logs filled by the monitor.
    int          acc_q[$], rise_q[$], resc_e[$], resx_e[$];
    logic        tx_type_q[$];
    logic [31:0] tx_seq_q[$], rep_q[$];
    logic [1:0]  resc_q[$], resx_q[$];

    udt_conn_ctrl #(.RETRY_CYCLES(RC), .MAX_RETRY(MR)) dut (
        .ctrl_s_axi_aclk(clk), .ctrl_s_axi_areset(rst),
        .Req_Connect(Req_Connect), .Req_Close(Req_Close),
        .Res_Connect(Res_Connect), .Res_Close(Res_Close), .err_code(err_code),
        .INIT_SEQ(INIT_SEQ),
        .hs_tx_valid(hs_tx_valid), .hs_tx_ready(hs_tx_ready), .hs_tx_type(hs_tx_type),
        .hs_tx_seq(hs_tx_seq),
        .hs_rx_valid(hs_rx_valid), .hs_rx_type(hs_rx_type), .hs_rx_ready(hs_rx_ready),
        .udt_state(udt_state), .state_valid(state_valid), .state_ready(state_ready)
    );

    always #5 clk = ~clk;

    // Edge counter; an event sampled at a negedge belongs to edge cyc+1.
    always @(posedge clk) cyc++;

    // Monitor on the falling edge.
    always @(negedge clk) begin
        if (hs_tx_valid && !prev_v) rise_q.push_back(cyc);
        prev_v = hs_tx_valid;
        if (hs_tx_valid && hs_tx_ready) begin
            acc_q.push_back(cyc + 1);
            tx_type_q.push_back(hs_tx_type);
            tx_seq_q.push_back(hs_tx_seq);
        end
        if (Res_Connect) begin resc_q.push_back(err_code); resc_e.push_back(cyc); end
        if (Res_Close)   begin resx_q.push_back(err_code); resx_e.push_back(cyc); end
        if (state_valid && state_ready) rep_q.push_back(udt_state);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        hs_tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick;
    endtask

    task automatic clear_logs;
        acc_q.delete(); rise_q.delete(); resc_e.delete(); resx_e.delete();
        tx_type_q.delete(); tx_seq_q.delete(); rep_q.delete();
        resc_q.delete(); resx_q.delete();
    endtask

    task automatic send_rx(input logic t);
        hs_rx_valid = 1'b1;
        hs_rx_type  = t;
        rx_e        = cyc + 1;
        tick;
        hs_rx_valid = 1'b0;
        hs_rx_type  = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int b = 0;
        while (acc_q.size() < n && b < 400) begin tick; b++; end
        chk("wait_tx_bound", 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_res(input bit close);
        int b = 0;
        while ((close ? resx_q.size() : resc_q.size()) == 0 && b < 600) begin tick; b++; end
        chk("wait_res_bound", 32'(b < 600), 32'd1);
    endtask

    // One connect (is_close=0) or close (is_close=1) attempt; the peer answers
    // after the k-th transmission, or never when k==0.
    task automatic run_attempt(input bit is_close, input int k, input bit bp, input logic [31:0] seq);
        int exp_n, sz;
        clear_logs;
        bp_mode = bp;
        exp_n = (k > 0) ? k : MR;
        if (!is_close) begin
            INIT_SEQ = seq; cur_seq = seq; Req_Connect = 1'b1;
        end else begin
            Req_Close = 1'b1;
        end
        req_edge = cyc + 1;
        tick;
        INIT_SEQ = ~cur_seq;
        if (k > 0) begin
            wait_tx(k);
            if ($urandom_range(0, 1) == 1) begin tick; send_rx(!is_close); end
            ticks($urandom_range(1, 4));
            send_rx(is_close);
        end
        wait_res(is_close);
        if (is_close) Req_Close = 1'b0; else Req_Connect = 1'b0;
        ticks(3);
        bp_mode = 1'b0;

        chk("tx_cnt", acc_q.size(), exp_n);
        foreach (tx_type_q[i]) begin
            chk("tx_type", 32'(tx_type_q[i]), 32'(is_close));
            chk("tx_seq", tx_seq_q[i], cur_seq);
        end
        chk("req_to_valid", (rise_q.size() > 0) ? rise_q[0] : -1, req_edge);
        for (int i = 1; i < rise_q.size(); i++)
            if (i - 1 < acc_q.size()) chk("retry_gap", rise_q[i] - acc_q[i-1], RC);
        sz = is_close ? resx_q.size() : resc_q.size();
        chk("res_cnt", sz, 1);
        chk("other_res_cnt", is_close ? resc_q.size() : resx_q.size(), 0);
        if (sz > 0) begin
            chk("res_err", 32'(is_close ? resx_q[0] : resc_q[0]), (k > 0) ? 32'd0 : 32'd1);
            if (k > 0)
                chk("res_latency", is_close ? resx_e[0] : resc_e[0], rx_e);
            else if (acc_q.size() > 0)
                chk("res_timeout_edge", is_close ? resx_e[0] : resc_e[0], acc_q[acc_q.size()-1] + RC);
        end
        if (state_ready) begin
            chk("rep_cnt", rep_q.size(), 2);
            if (rep_q.size() == 2) begin
                chk("rep0", rep_q[0], is_close ? C_CLSG : C_CONN);
                chk("rep1", rep_q[1], (k > 0 && !is_close) ? C_UP : C_CLSD);
            end
        end else begin
            chk("rep_none", rep_q.size(), 0);
        end
    endtask

    initial begin
        Req_Connect = 0; Req_Close = 0; INIT_SEQ = 0; hs_tx_ready = 1;
        hs_rx_valid = 0; hs_rx_type = 0; state_ready = 1;
        rst = 1;
        ticks(3);
        chk("rst_udt_state", udt_state, C_INIT);
        chk("rst_state_valid", 32'(state_valid), 0);
        chk("rst_tx_valid", 32'(hs_tx_valid), 0);
        chk("rst_rx_ready", 32'(hs_rx_ready), 0);
        chk("rst_res", 32'({Res_Connect, Res_Close}), 0);
        chk("rst_err", 32'(err_code), 0);
        chk("rst_seq", hs_tx_seq, 0);
        rst = 0;
        ticks(2);

        // Close while never opened: single illegal response although held.
        clear_logs;
        Req_Close = 1; ticks(5); Req_Close = 0; ticks(2);
        chk("idle_close_cnt", resx_q.size(), 1);
        chk("idle_close_err", (resx_q.size() > 0) ? 32'(resx_q[0]) : 32'd3, 2);
        chk("idle_close_state", udt_state, C_INIT);
        chk("idle_close_rep", rep_q.size(), 0);

        // Directed connect with a fixed sequence number.
        run_attempt(0, 1, 0, 32'h1234);
        chk("t1_state", udt_state, C_UP);

        // Illegal connect while up.
        clear_logs;
        Req_Connect = 1; ticks(5); Req_Connect = 0; ticks(2);
        chk("up_conn_cnt", resc_q.size(), 1);
        chk("up_conn_err", (resc_q.size() > 0) ? 32'(resc_q[0]) : 32'd3, 2);
        chk("up_conn_rep", rep_q.size(), 0);
        // Handshake response while up is dropped.
        clear_logs;
        send_rx(0); ticks(3);
        chk("up_rx0_rep", rep_q.size(), 0);
        chk("up_rx_ready", 32'(hs_rx_ready), 1);
        // Peer shutdown while up.
        clear_logs;
        send_rx(1); ticks(2);
        chk("peer_close_rep", rep_q.size(), 1);
        chk("peer_close_code", (rep_q.size() > 0) ? rep_q[0] : 32'hx, C_CLSD);
        chk("peer_close_nores", resc_q.size() + resx_q.size(), 0);
        // Close while closed.
        clear_logs;
        Req_Close = 1; ticks(5); Req_Close = 0; ticks(2);
        chk("closed_close_cnt", resx_q.size(), 1);
        chk("closed_close_err", (resx_q.size() > 0) ? 32'(resx_q[0]) : 32'd3, 2);

        // Timeout with no peer answer.
        run_attempt(0, 0, 0, $urandom);
        chk("t2_state", udt_state, C_CLSD);

        // Both requests at once: close is answered first, connect follows.
        clear_logs;
        cur_seq = $urandom; INIT_SEQ = cur_seq;
        Req_Close = 1; Req_Connect = 1;
        wait_tx(1); ticks(2); send_rx(0);
        wait_res(0);
        Req_Close = 0; Req_Connect = 0; ticks(3);
        chk("both_close_cnt", resx_q.size(), 1);
        chk("both_close_err", (resx_q.size() > 0) ? 32'(resx_q[0]) : 32'd3, 2);
        chk("both_order", (rise_q.size() > 0 && resx_e.size() > 0) ? rise_q[0] - resx_e[0] : -1, 1);
        chk("both_conn_err", (resc_q.size() > 0) ? 32'(resc_q[0]) : 32'd3, 0);
        chk("both_state", udt_state, C_UP);

        // Close answered after the second shutdown.
        run_attempt(1, 2, 0, 0);
        chk("t3_state", udt_state, C_CLSD);

        // Randomized rounds with optional tx backpressure.
        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(0, MR);
            run_attempt(0, k, 1'($urandom_range(0, 1)), $urandom);
            if (k > 0) run_attempt(1, $urandom_range(0, MR), 1'($urandom_range(0, 1)), 0);
        end

        // State report backpressure: latest value wins, valid held.
        state_ready = 0;
        run_attempt(0, 1, 0, $urandom);
        chk("bp_valid_held", 32'(state_valid), 1);
        chk("bp_latest", udt_state, C_UP);
        clear_logs;
        state_ready = 1;
        tick;
        chk("bp_valid_clear", 32'(state_valid), 0);
        chk("bp_rep_cnt", rep_q.size(), 1);
        chk("bp_rep_code", (rep_q.size() > 0) ? rep_q[0] : 32'hx, C_UP);

        // Reset while waiting for a handshake answer.
        run_attempt(1, 1, 0, 0);
        clear_logs;
        cur_seq = $urandom | 32'h1; INIT_SEQ = cur_seq;
        Req_Connect = 1;
        wait_tx(1); ticks(3);
        #2 rst = 1;
        #1;
        chk("mid_rst_state", udt_state, C_INIT);
        chk("mid_rst_valid", 32'(state_valid), 0);
        chk("mid_rst_rx_ready", 32'(hs_rx_ready), 0);
        chk("mid_rst_tx_valid", 32'(hs_tx_valid), 0);
        chk("mid_rst_seq", hs_tx_seq, 0);
        chk("mid_rst_res", 32'({Res_Connect, Res_Close, err_code}), 0);
        Req_Connect = 0;
        ticks(2);
        rst = 0;
        ticks(2);
        chk("post_rst_nores", resc_q.size() + resx_q.size(), 0);
        run_attempt(0, 0, 0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
